// File: rtl/prog_sequencer.sv
// Programmable instruction sequencer: selects one of NPROG start addresses, fetches
// over a variable-latency request/valid handshake, executes with stall and branch support.
module prog_sequencer #(
   parameter int AW = 10,
   parameter int IW = 9,
   parameter int NPROG = 4,
   parameter int STRIDE = 256,
   parameter int CW = 16,
   parameter logic [IW-1:0] HALT = '0,
   localparam int PSW = (NPROG > 1) ? $clog2(NPROG) : 1
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic [PSW-1:0] ProgSel,
   output logic           InstReq,
   output logic [AW-1:0]  InstAddr,
   input  logic           InstValid,
   input  logic [IW-1:0]  InstData,
   output logic [IW-1:0]  Instruction,
   output logic           Exec,
   input  logic           Stall,
   input  logic           BranchEn,
   input  logic           BranchTaken,
   input  logic           BranchAbs,
   input  logic [AW-1:0]  Target,
   output logic           Ack,
   output logic [CW-1:0]  CycleCt,
   output logic [CW-1:0]  InstrCt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state;
   logic [AW-1:0] pc;
   logic [AW-1:0] start_pc;
   logic [AW-1:0] next_pc;
   logic [IW-1:0] instr_reg;
   logic [CW-1:0] cycle_ct;
   logic [CW-1:0] instr_ct;
   logic          is_halt;

   // Truncating both operands to AW bits keeps the product congruent mod 2^AW.
   assign start_pc = AW'(ProgSel) * AW'(STRIDE);
   assign is_halt  = (instr_reg == HALT);

   always_comb begin
      next_pc = pc + AW'(1);
      if (BranchEn && BranchTaken) begin
         if (BranchAbs) begin
            next_pc = Target;
         end else begin
            next_pc = pc + Target;
         end
      end
   end

   // Start overrides every other transition; counters saturate at all-ones.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         pc        <= '0;
         instr_reg <= '0;
         cycle_ct  <= '0;
         instr_ct  <= '0;
      end else if (Start) begin
         state    <= S_FETCH;
         pc       <= start_pc;
         cycle_ct <= '0;
         instr_ct <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               state <= S_WAIT;
               if (cycle_ct != '1) cycle_ct <= cycle_ct + CW'(1);
            end
            S_WAIT: begin
               if (cycle_ct != '1) cycle_ct <= cycle_ct + CW'(1);
               if (InstValid) begin
                  instr_reg <= InstData;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cycle_ct != '1) cycle_ct <= cycle_ct + CW'(1);
               if (is_halt) begin
                  state <= S_DONE;
               end else if (!Stall) begin
                  state <= S_FETCH;
                  pc    <= next_pc;
                  if (instr_ct != '1) instr_ct <= instr_ct + CW'(1);
               end
            end
            S_IDLE, S_DONE: begin
               state <= state;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign InstReq     = (state == S_FETCH);
   assign Exec        = (state == S_EXEC);
   assign Ack         = (state == S_DONE);
   assign InstAddr    = pc;
   assign Instruction = instr_reg;
   assign CycleCt     = cycle_ct;
   assign InstrCt     = instr_ct;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer: a transaction-level model tracks
// expected PC, cycle and instruction counts per fetched instruction.
module tb_prog_sequencer;

   localparam logic [8:0] HALT_WORD = 9'd0;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] progSel;
   logic       instReq;
   logic [9:0] instAddr;
   logic       instValid;
   logic [8:0] instData;
   logic [8:0] instruction;
   logic       exec;
   logic       stall;
   logic       branchEn;
   logic       branchTaken;
   logic       branchAbs;
   logic [9:0] target;
   logic       ack;
   logic [15:0] cycleCt;
   logic [15:0] instrCt;

   int checkCount = 0;
   int errorCount = 0;
   int expPc;
   int expCycles;
   int expInstrs;

   prog_sequencer dut (
      .Clk(clk), .Reset(reset), .Start(start), .ProgSel(progSel),
      .InstReq(instReq), .InstAddr(instAddr), .InstValid(instValid), .InstData(instData),
      .Instruction(instruction), .Exec(exec), .Stall(stall),
      .BranchEn(branchEn), .BranchTaken(branchTaken), .BranchAbs(branchAbs), .Target(target),
      .Ack(ack), .CycleCt(cycleCt), .InstrCt(instrCt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Program counter rule stated with plain signed integer arithmetic on a 1024-word space.
   function automatic int modelNextPc(input int pc, input logic en, input logic taken,
                                      input logic abs, input logic [9:0] tgt);
      int off;
      if (en && taken && abs) return int'(tgt);
      if (en && taken) begin
         off = int'(tgt);
         if (off >= 512) off -= 1024;
         return (pc + off + 1024) % 1024;
      end
      return (pc + 1) % 1024;
   endfunction

   task automatic randomBranch();
      branchEn    = 1'($urandom);
      branchTaken = 1'($urandom);
      branchAbs   = 1'($urandom);
      target      = 10'($urandom);
   endtask

   task automatic startProgram(input int sel);
      start   = 1'b1;
      progSel = 2'(sel);
      @(negedge clk);
      start   = 1'b0;
      progSel = 2'($urandom);
      expPc     = (sel * 256) % 1024;
      expCycles = 0;
      expInstrs = 0;
   endtask

   // One instruction from its FETCH cycle through commit (or DONE for HALT).
   task automatic applyStimulus(input logic [8:0] word, input int lat, input int stalls,
                                input logic en, input logic taken, input logic abs,
                                input logic [9:0] tgt);
      checkOutput("fetchReq", 32'(instReq), 1);
      checkOutput("fetchAddr", 32'(instAddr), expPc);
      checkOutput("fetchCycleCt", 32'(cycleCt), expCycles);
      checkOutput("fetchInstrCt", 32'(instrCt), expInstrs);
      instValid = 1'($urandom);
      instData  = 9'($urandom);
      @(negedge clk); expCycles++;
      for (int w = 1; w <= lat; w++) begin
         checkOutput("waitReq", 32'(instReq), 0);
         checkOutput("waitExec", 32'(exec), 0);
         checkOutput("waitCycleCt", 32'(cycleCt), expCycles);
         instValid = (w == lat);
         instData  = (w == lat) ? word : 9'($urandom);
         @(negedge clk); expCycles++;
      end
      if (word == HALT_WORD) begin
         checkOutput("haltExec", 32'(exec), 1);
         instValid = 1'($urandom);
         instData  = 9'($urandom);
         stall     = 1'($urandom);
         randomBranch();
         @(negedge clk); expCycles++;
         instValid = 1'b0;
         stall     = 1'b0;
         checkOutput("doneAck", 32'(ack), 1);
         checkOutput("doneExec", 32'(exec), 0);
         checkOutput("doneAddr", 32'(instAddr), expPc);
         checkOutput("doneCycleCt", 32'(cycleCt), expCycles);
         checkOutput("doneInstrCt", 32'(instrCt), expInstrs);
         return;
      end
      for (int s = 0; s <= stalls; s++) begin
         checkOutput("execFlag", 32'(exec), 1);
         checkOutput("execInstr", 32'(instruction), 32'(word));
         checkOutput("execAddr", 32'(instAddr), expPc);
         checkOutput("execInstrCt", 32'(instrCt), expInstrs);
         checkOutput("execCycleCt", 32'(cycleCt), expCycles);
         instValid = 1'($urandom);
         instData  = 9'($urandom);
         stall     = (s < stalls);
         if (s < stalls) begin
            randomBranch();
         end else begin
            branchEn = en; branchTaken = taken; branchAbs = abs; target = tgt;
         end
         @(negedge clk); expCycles++;
      end
      instValid = 1'b0; stall = 1'b0;
      branchEn = 1'b0; branchTaken = 1'b0; branchAbs = 1'b0; target = '0;
      expInstrs++;
      expPc = modelNextPc(expPc, en, taken, abs, tgt);
   endtask

   task automatic checkDoneHold(input int n);
      for (int i = 0; i < n; i++) begin
         instValid = 1'($urandom);
         @(negedge clk);
         checkOutput("holdAck", 32'(ack), 1);
         checkOutput("holdCycleCt", 32'(cycleCt), expCycles);
         checkOutput("holdInstrCt", 32'(instrCt), expInstrs);
      end
      instValid = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "Req"}, 32'(instReq), 0);
      checkOutput({tag, "Exec"}, 32'(exec), 0);
      checkOutput({tag, "Ack"}, 32'(ack), 0);
      checkOutput({tag, "Addr"}, 32'(instAddr), 0);
      checkOutput({tag, "Instr"}, 32'(instruction), 0);
      checkOutput({tag, "CycleCt"}, 32'(cycleCt), 0);
      checkOutput({tag, "InstrCt"}, 32'(instrCt), 0);
   endtask

   task automatic runRandomProgram();
      logic [8:0] word;
      startProgram($urandom_range(0, 3));
      for (int n = 0; n < 25; n++) begin
         if (n == 24 || $urandom_range(0, 7) == 0) begin
            applyStimulus(HALT_WORD, $urandom_range(1, 5), 0, 0, 0, 0, 0);
            break;
         end
         word = 9'($urandom_range(1, 511));
         applyStimulus(word, $urandom_range(1, 5), $urandom_range(0, 4), 1'($urandom),
                       1'($urandom), 1'($urandom), 10'($urandom));
      end
      checkDoneHold(2);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; progSel = '0; instValid = 1'b0; instData = '0;
      stall = 1'b0; branchEn = 1'b0; branchTaken = 1'b0; branchAbs = 1'b0; target = '0;
      expPc = 0; expCycles = 0; expInstrs = 0;
      repeat (2) @(negedge clk);
      checkResetValues("rst");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("idle");

      // Straight-line program from slot 2 with single-cycle memory latency.
      startProgram(2);
      for (int i = 0; i < 3; i++) applyStimulus(9'(i + 17), 1, 0, 0, 0, 0, 0);
      applyStimulus(HALT_WORD, 1, 0, 0, 0, 0, 0);
      checkOutput("seqAddr", 32'(instAddr), 515);
      checkOutput("seqInstrCt", 32'(instrCt), 3);
      checkOutput("seqCycleCt", 32'(cycleCt), 12);
      checkDoneHold(3);

      // Relative branch at PC 5, taken then not taken.
      startProgram(0);
      applyStimulus(9'd33, 1, 0, 1, 1, 1, 10'd5);
      applyStimulus(9'd34, 2, 0, 1, 1, 0, 10'h3FD);
      checkOutput("relTaken", 32'(instAddr), 2);
      applyStimulus(9'd35, 1, 0, 1, 1, 1, 10'd5);
      applyStimulus(9'd36, 1, 0, 1, 0, 0, 10'h3FD);
      checkOutput("relNotTaken", 32'(instAddr), 6);

      // Absolute branch at the top address: wrap when not taken, jump when taken.
      applyStimulus(9'd37, 1, 0, 1, 1, 1, 10'd1023);
      applyStimulus(9'd38, 1, 0, 1, 0, 1, 10'd7);
      checkOutput("absWrap", 32'(instAddr), 0);
      applyStimulus(9'd39, 1, 0, 1, 1, 1, 10'd1023);
      applyStimulus(9'd40, 1, 0, 1, 1, 1, 10'd7);
      checkOutput("absTaken", 32'(instAddr), 7);

      // Four-cycle stall with a slow fetch.
      applyStimulus(9'd41, $urandom_range(1, 5), 4, 0, 0, 0, 0);
      applyStimulus(9'd42, $urandom_range(1, 5), 4, 1, 1, 0, 10'd3);
      applyStimulus(HALT_WORD, 3, 0, 0, 0, 0, 0);

      // Asynchronous reset in WAIT with a simultaneous Start.
      startProgram(3);
      applyStimulus(9'd99, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("preRstWait", 32'(instReq), 0);
      #2;
      reset = 1'b1;
      start = 1'b1;
      #1;
      checkResetValues("asyncRst");
      @(negedge clk);
      checkResetValues("rstStart");
      start = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("postRst");
      startProgram(1);
      applyStimulus(9'd77, 2, 1, 0, 0, 0, 0);
      applyStimulus(HALT_WORD, 1, 0, 0, 0, 0, 0);

      // Restart from EXEC, then re-run from DONE.
      startProgram(0);
      applyStimulus(9'd10, 1, 0, 0, 0, 0, 0);
      applyStimulus(9'd11, 2, 0, 0, 0, 0, 0);
      @(negedge clk);
      instValid = 1'b1; instData = 9'd12;
      @(negedge clk);
      instValid = 1'b0;
      checkOutput("preRestartExec", 32'(exec), 1);
      stall = 1'b1;
      startProgram(1);
      stall = 1'b0;
      checkOutput("restartAddr", 32'(instAddr), 256);
      checkOutput("restartCycleCt", 32'(cycleCt), 0);
      checkOutput("restartInstrCt", 32'(instrCt), 0);
      applyStimulus(9'd13, 1, 2, 0, 0, 0, 0);
      applyStimulus(HALT_WORD, 1, 0, 0, 0, 0, 0);
      startProgram(1);
      checkOutput("rerunAck", 32'(ack), 0);
      checkOutput("rerunAddr", 32'(instAddr), 256);
      applyStimulus(9'd14, 1, 0, 0, 0, 0, 0);
      applyStimulus(HALT_WORD, 2, 0, 0, 0, 0, 0);

      for (int p = 0; p < 12; p++) runRandomProgram();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
